// File: rtl/axis_governor_ctrl.sv
// Debug sequencer for an axis_governor: drives pause/drop/log_en from a command
// stream, counts accepted flits/packets and auto-halts after N steps or a breakpoint.
module axis_governor_ctrl #(
  parameter int DEST_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CNT_WIDTH-1:0]  cmd_arg,
  input  logic                  mon_TVALID,
  input  logic                  mon_TREADY,
  input  logic                  mon_TLAST,
  input  logic [DEST_WIDTH-1:0] mon_TDEST,
  output logic                  pause,
  output logic                  drop,
  output logic                  log_en,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  flit_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic                  halted
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } state_t;

  localparam logic [2:0] OP_HALT     = 3'd1;
  localparam logic [2:0] OP_RUN      = 3'd2;
  localparam logic [2:0] OP_STEP     = 3'd3;
  localparam logic [2:0] OP_BRK      = 3'd4;
  localparam logic [2:0] OP_SET_MODE = 3'd5;
  localparam logic [2:0] OP_CLR_CNT  = 3'd6;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  pause_q, pause_d;
  logic                  drop_q, drop_d;
  logic                  log_en_q, log_en_d;
  logic                  halted_q, halted_d;
  logic [CNT_WIDTH-1:0]  flit_cnt_q, flit_cnt_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DEST_WIDTH-1:0] bp_dest_q, bp_dest_d;
  logic                  bp_eop_q, bp_eop_d;

  logic fire_s, cmd_acc_s, cmd_ctrl_s, bp_match_s;

  assign fire_s     = mon_TVALID & mon_TREADY;
  assign cmd_acc_s  = cmd_valid & cmd_ready_q;
  assign cmd_ctrl_s = (cmd_op == OP_HALT) | (cmd_op == OP_RUN) |
                      (cmd_op == OP_STEP) | (cmd_op == OP_BRK);
  assign bp_match_s = bp_eop_q ? mon_TLAST : (mon_TDEST == bp_dest_q);

  // Next-state logic: state-changing commands take priority over step/breakpoint events
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b1;
    drop_d      = drop_q;
    log_en_d    = log_en_q;
    halted_d    = 1'b0;
    flit_cnt_d  = flit_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    remaining_d = remaining_q;
    bp_dest_d   = bp_dest_q;
    bp_eop_d    = bp_eop_q;

    if (cmd_acc_s && (cmd_op == OP_CLR_CNT)) begin
      flit_cnt_d = '0;
      pkt_cnt_d  = '0;
    end else if (fire_s) begin
      flit_cnt_d = flit_cnt_q + CNT_ONE;
      pkt_cnt_d  = pkt_cnt_q + CNT_WIDTH'(mon_TLAST);
    end else begin
      flit_cnt_d = flit_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
    end

    if (cmd_acc_s && (cmd_op == OP_SET_MODE)) begin
      drop_d   = cmd_arg[0];
      log_en_d = cmd_arg[1];
    end else begin
      drop_d   = drop_q;
      log_en_d = log_en_q;
    end

    if (cmd_acc_s && cmd_ctrl_s) begin
      case (cmd_op)
        OP_HALT: state_d = ST_HALT;
        OP_RUN:  state_d = ST_RUN;
        OP_STEP: begin
          if (cmd_arg == '0) begin
            state_d = ST_HALT;
          end else begin
            remaining_d = cmd_arg;
            state_d     = ST_STEP;
          end
        end
        OP_BRK: begin
          bp_dest_d = cmd_arg[DEST_WIDTH-1:0];
          bp_eop_d  = cmd_arg[CNT_WIDTH-1];
          state_d   = ST_BRK;
        end
        default: state_d = state_q;
      endcase
    end else if (fire_s && (state_q == ST_STEP)) begin
      if (remaining_q == CNT_ONE) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end else begin
        remaining_d = remaining_q - CNT_ONE;
      end
    end else if (fire_s && (state_q == ST_BRK) && bp_match_s) begin
      state_d  = ST_HALT;
      halted_d = 1'b1;
    end else begin
      state_d = state_q;
    end

    // pause tracks the next state so it rises in the same cycle HALT is entered
    pause_d = (state_d == ST_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_HALT;
      cmd_ready_q <= 1'b0;
      pause_q     <= 1'b1;
      drop_q      <= 1'b0;
      log_en_q    <= 1'b0;
      halted_q    <= 1'b0;
      flit_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      remaining_q <= '0;
      bp_dest_q   <= '0;
      bp_eop_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      pause_q     <= pause_d;
      drop_q      <= drop_d;
      log_en_q    <= log_en_d;
      halted_q    <= halted_d;
      flit_cnt_q  <= flit_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      remaining_q <= remaining_d;
      bp_dest_q   <= bp_dest_d;
      bp_eop_q    <= bp_eop_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign pause     = pause_q;
  assign drop      = drop_q;
  assign log_en    = log_en_q;
  assign state     = state_q;
  assign flit_cnt  = flit_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign halted    = halted_q;

endmodule
